// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: captures one camera frame into an external single-port
// frame buffer, then reads it back and streams each 30-bit pixel as three
// 8-bit colour bytes (top 8 bits of R, G, B) on a valid/ready interface.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   arm                 one-cycle request to capture the next frame
//   start_frame         sensor start-of-frame, coincident with first pixel
//   pixel_valid/in      sensor pixel stream {R[29:20], G[19:10], B[9:0]}
//   mem_we/re/addr/...  frame buffer port; mem_rdata valid 1 cycle after mem_re
//   out_data/valid/ready colour byte stream
//   busy                high whenever not idle
//   frame_done          one-cycle pulse after the last byte is accepted
//   restart_err         sticky, set on start_frame mid-capture, cleared by arm
module frame_buffer_ctrl #(
    parameter int unsigned HEIGHT = 240,
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned ADDR_W = $clog2(HEIGHT * WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              start_frame,
    input  logic              pixel_valid,
    input  logic [29:0]       pixel_in,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [29:0]       mem_wdata,
    input  logic [29:0]       mem_rdata,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              restart_err
);

    localparam int unsigned       N    = HEIGHT * WIDTH;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_SOF, CAPTURE, RD_ISSUE, RD_LATCH, SEND
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_cnt, wr_cnt_n;
    logic [ADDR_W-1:0] rd_cnt, rd_cnt_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [29:0]       pix, pix_n;
    logic              restart_err_n;
    logic              frame_done_n;
    logic              we_c;
    logic [ADDR_W-1:0] waddr_c;

    // Top 8 bits of the selected colour channel.
    function automatic logic [7:0] pick(input logic [29:0] p, input logic [1:0] idx);
        case (idx)
            2'd0:    return p[29:22];
            2'd1:    return p[19:12];
            default: return p[9:2];
        endcase
    endfunction

    // Next-state, counters and the combinational capture write port.
    always_comb begin
        state_n       = state;
        wr_cnt_n      = wr_cnt;
        rd_cnt_n      = rd_cnt;
        byte_idx_n    = byte_idx;
        pix_n         = pix;
        restart_err_n = restart_err;
        frame_done_n  = 1'b0;
        we_c          = 1'b0;
        waddr_c       = '0;

        case (state)
            IDLE: begin
                if (arm) begin
                    state_n       = WAIT_SOF;
                    restart_err_n = 1'b0;
                end
            end
            WAIT_SOF: begin
                if (start_frame && pixel_valid) begin
                    we_c = 1'b1;
                end
            end
            CAPTURE: begin
                if (pixel_valid) begin
                    we_c = 1'b1;
                    if (start_frame) begin
                        restart_err_n = 1'b1;
                    end else begin
                        waddr_c = wr_cnt;
                    end
                end
            end
            RD_ISSUE: state_n = RD_LATCH;
            RD_LATCH: begin
                pix_n      = mem_rdata;
                byte_idx_n = 2'd0;
                state_n    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (byte_idx != 2'd2) begin
                        byte_idx_n = byte_idx + 2'd1;
                    end else if (rd_cnt != LAST) begin
                        rd_cnt_n = rd_cnt + ADDR_W'(1);
                        state_n  = RD_ISSUE;
                    end else begin
                        frame_done_n = 1'b1;
                        state_n      = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Any write advances the capture; the write to the last address hands over to readout.
        if (we_c) begin
            if (waddr_c == LAST) begin
                state_n  = RD_ISSUE;
                rd_cnt_n = '0;
                wr_cnt_n = '0;
            end else begin
                state_n  = CAPTURE;
                wr_cnt_n = waddr_c + ADDR_W'(1);
            end
        end
    end

    // rd_cnt is stable for the whole read cycle, so it can drive the address directly.
    assign mem_we    = we_c;
    assign mem_addr  = we_c ? waddr_c : rd_cnt;
    assign mem_wdata = we_c ? pixel_in : '0;

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            byte_idx    <= '0;
            pix         <= '0;
            mem_re      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            restart_err <= 1'b0;
        end else begin
            state       <= state_n;
            wr_cnt      <= wr_cnt_n;
            rd_cnt      <= rd_cnt_n;
            byte_idx    <= byte_idx_n;
            pix         <= pix_n;
            mem_re      <= (state_n == RD_ISSUE);
            out_valid   <= (state_n == SEND);
            out_data    <= pick(pix_n, byte_idx_n);
            busy        <= (state_n != IDLE);
            frame_done  <= frame_done_n;
            restart_err <= restart_err_n;
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl (2x2 frame). A behavioural model of the
// capture/readout rules predicts every output each cycle; a bench-side RAM
// models the frame buffer; literal expectations pin the model.
module tb_frame_buffer_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          reset, arm, start_frame, pixel_valid, out_ready;
    logic [29:0]   pixel_in;
    logic [29:0]   mem_rdata = '0;
    logic [29:0]   mem_wdata;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [7:0]    out_data;
    logic          out_valid, busy, frame_done, restart_err;

    frame_buffer_ctrl #(.HEIGHT(2), .WIDTH(2)) dut (
        .clk(clk), .reset(reset), .arm(arm), .start_frame(start_frame),
        .pixel_valid(pixel_valid), .pixel_in(pixel_in), .mem_we(mem_we),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .frame_done(frame_done),
        .restart_err(restart_err)
    );

    always #5 clk = ~clk;

    // Frame buffer RAM with one-cycle read latency.
    logic [29:0] ram [N];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Sink readiness: manual, 1,0,0,1 pattern, or random.
    int   ready_mode   = 0;
    logic ready_manual = 1'b1;
    logic ready_auto   = 1'b1;
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    assign out_ready = (ready_mode == 0) ? ready_manual : ready_auto;
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1) ready_auto = pat[ph % 4];
            else                 ready_auto = 1'($urandom_range(0, 1));
            ph++;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [29:0] p, input int k);
        // Channel k (R=0, G=1, B=2) is 10 bits wide; keep its top 8 bits.
        return 8'(p >> (22 - 10 * k));
    endfunction

    // Behavioural model: mode 0 idle, 1 armed, 2 capturing, 3 reading out.
    // In readout, step 0 = read issued, 1 = data returning, 2..4 = bytes R,G,B.
    int          m_mode = 0, m_wcnt = 0, m_pix = 0, m_step = 0;
    bit          m_rerr = 0, m_done = 0;
    logic [29:0] m_mem [N];
    bit          chk_en = 0;
    int          done_cnt = 0, re_cnt = 0;
    logic [7:0]  acc_q [$];

    always @(negedge clk) begin
        bit sof, exp_we, exp_re, exp_ov;
        int a;
        sof    = start_frame && pixel_valid;
        exp_we = (m_mode == 1 && sof) || (m_mode == 2 && pixel_valid);
        exp_re = (m_mode == 3 && m_step == 0);
        exp_ov = (m_mode == 3 && m_step >= 2);
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_mode != 0));
            check("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
                check("wr_addr", 32'(mem_addr), start_frame ? 0 : 32'(m_wcnt));
                check("wr_data", 32'(mem_wdata), 32'(pixel_in));
            end
            check("mem_re", 32'(mem_re), 32'(exp_re));
            if (exp_re) check("rd_addr", 32'(mem_addr), 32'(m_pix));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) check("out_data", 32'(out_data), 32'(byte_of(m_mem[m_pix], m_step - 2)));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("restart_err", 32'(restart_err), 32'(m_rerr));
            if (out_valid && out_ready) acc_q.push_back(out_data);
            if (frame_done) done_cnt++;
            if (mem_re) re_cnt++;
        end
        // Advance the model to what the coming clock edge produces.
        if (reset) begin
            m_mode = 0; m_rerr = 0; m_done = 0; m_wcnt = 0;
        end else begin
            m_done = 0;
            case (m_mode)
                0: if (arm) begin m_mode = 1; m_rerr = 0; end
                1: if (sof) begin m_mem[0] = pixel_in; m_wcnt = 1; m_mode = 2; end
                2: if (pixel_valid) begin
                    a = start_frame ? 0 : m_wcnt;
                    if (start_frame) m_rerr = 1;
                    m_mem[a] = pixel_in;
                    m_wcnt = a + 1;
                    if (a == N - 1) begin m_mode = 3; m_pix = 0; m_step = 0; end
                end
                default: begin
                    if (m_step < 2) m_step++;
                    else if (out_ready) begin
                        if (m_step < 4) m_step++;
                        else if (m_pix < N - 1) begin m_pix++; m_step = 0; end
                        else begin m_mode = 0; m_done = 1; end
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pix(input logic [29:0] v, input bit sof);
        pixel_valid = 1'b1; start_frame = sof; pixel_in = v;
        tick();
        pixel_valid = 1'b0; start_frame = 1'b0; pixel_in = 30'($urandom);
    endtask

    task automatic do_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        check("wait_idle_timeout", 32'(busy), 0);
        tick();
    endtask

    task automatic check_ram(input string name, input logic [29:0] v [N]);
        for (int i = 0; i < N; i++) check(name, 32'(ram[i]), 32'(v[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [29:0] fr [N];
        logic [7:0]  exp_bytes [12];
        int          sent;

        reset = 1'b1; arm = 1'b0; start_frame = 1'b0; pixel_valid = 1'b0; pixel_in = '0;
        tick(); tick();
        chk_en = 1;
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_restart_err", 32'(restart_err), 0);
        reset = 1'b0;
        tick();

        // Sensor traffic before arm, then pixels without SOF while armed.
        pix(30'($urandom), 1'b1);
        pix(30'($urandom), 1'b0);
        do_arm();
        check("armed_busy", 32'(busy), 1);
        pix(30'($urandom), 1'b0);
        pix(30'($urandom), 1'b0);
        check("wait_no_we_busy", 32'(busy), 1);

        // Directed frame with known byte stream.
        acc_q.delete(); done_cnt = 0; re_cnt = 0;
        fr = '{30'h3FF00000, 30'h000FFC00, 30'h000003FF, 30'h2AAAAAAA};
        exp_bytes = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00,
                      8'h00, 8'h00, 8'hFF, 8'hAA, 8'hAA, 8'hAA};
        for (int i = 0; i < N; i++) pix(fr[i], i == 0);
        wait_idle(200);
        check_ram("ram_directed", fr);
        check("n_bytes", 32'(acc_q.size()), 12);
        for (int i = 0; i < 12 && i < acc_q.size(); i++) check("byte", 32'(acc_q[i]), 32'(exp_bytes[i]));
        check("done_cnt", 32'(done_cnt), 1);
        check("re_cnt", 32'(re_cnt), 4);

        // Throttled sink.
        ready_mode = 1;
        acc_q.delete(); done_cnt = 0; re_cnt = 0;
        do_arm();
        for (int i = 0; i < N; i++) begin fr[i] = 30'($urandom); pix(fr[i], i == 0); end
        wait_idle(400);
        check_ram("ram_throttled", fr);
        check("thr_n_bytes", 32'(acc_q.size()), 12);
        check("thr_re_cnt", 32'(re_cnt), 4);
        check("thr_done_cnt", 32'(done_cnt), 1);

        // Restart mid-capture.
        ready_mode = 0; ready_manual = 1'b1;
        do_arm();
        pix(30'($urandom), 1'b1);
        pix(30'($urandom), 1'b0);
        for (int i = 0; i < N; i++) begin
            fr[i] = 30'($urandom);
            pix(fr[i], i == 0);
            if (i == 0) check("restart_set", 32'(restart_err), 1);
        end
        wait_idle(200);
        check_ram("ram_restart", fr);
        check("restart_sticky", 32'(restart_err), 1);
        do_arm();
        check("restart_cleared", 32'(restart_err), 0);

        // Reset during SEND with byte_idx=1 (already armed above).
        ready_manual = 1'b0;
        for (int i = 0; i < N; i++) pix(30'($urandom), i == 0);
        sent = 0;
        while (!out_valid && sent < 20) begin tick(); sent++; end
        check("send_reached", 32'(out_valid), 1);
        ready_manual = 1'b1; tick(); ready_manual = 1'b0;
        reset = 1'b1; tick();
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_mem_we", 32'(mem_we), 0);
        check("abort_mem_re", 32'(mem_re), 0);
        reset = 1'b0; ready_manual = 1'b1; tick();
        done_cnt = 0; acc_q.delete();
        do_arm();
        for (int i = 0; i < N; i++) begin fr[i] = 30'($urandom); pix(fr[i], i == 0); end
        wait_idle(200);
        check_ram("ram_after_abort", fr);
        check("abort_done_cnt", 32'(done_cnt), 1);
        check("abort_n_bytes", 32'(acc_q.size()), 12);

        // arm during capture and readout, extra pixels after the last one.
        do_arm();
        fr[0] = 30'($urandom); pix(fr[0], 1'b1);
        arm = 1'b1; fr[1] = 30'($urandom); pix(fr[1], 1'b0); arm = 1'b0;
        for (int i = 2; i < N; i++) begin fr[i] = 30'($urandom); pix(fr[i], 1'b0); end
        pix(30'($urandom), 1'b0);
        pix(30'($urandom), 1'b1);
        sent = 0;
        while (!out_valid && sent < 20) begin tick(); sent++; end
        do_arm();
        wait_idle(200);
        check("arm_ignored_idle", 32'(busy), 0);
        check_ram("ram_extra", fr);

        // Randomised frames with gaps and random sink.
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            done_cnt = 0;
            do_arm();
            for (int g = $urandom_range(0, 3); g > 0; g--) pix(30'($urandom), 1'b0);
            sent = 0;
            while (sent < N) begin
                if ($urandom_range(0, 2) == 0) tick();
                else begin fr[sent] = 30'($urandom); pix(fr[sent], sent == 0); sent++; end
            end
            wait_idle(400);
            check_ram("ram_random", fr);
            check("rand_done_cnt", 32'(done_cnt), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
